alu_sequencer: RTL
==================

# alu_sequencer

- Sequential front-end that drives the combinational two's-complement ALU.
- Holds an accumulator, a carry register and a status-flag register.
- Accepts commands over a valid/ready handshake and runs each ALU operation 1..N times with the accumulator fed back as operand A. Typical uses are multi-bit shifts and repeated increments.
- Returns the final result and flags over a second valid/ready handshake. It sits directly upstream of the ALU: it feeds its operands, opcode and carry-in, and captures its outputs.

## Interface
Parameters:
- WIDTH, 8, datapath width; must match the ALU's WIDTH.
- CNTW, 4, width of the repeat-count field.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command (high only in IDLE).
- cmd_load  in  1  1 = load cmd_operand into the accumulator; cmd_op and cmd_count are ignored.
- cmd_op  in  4  ALU opcode, using the ALU opcode encoding.
- cmd_operand  in  WIDTH  operand B, or the load value.
- cmd_count  in  CNTW  number of repetitions; 0 is treated as 1.
- alu_a  out  WIDTH  driven from the accumulator.
- alu_b  out  WIDTH  driven from the latched operand.
- alu_op  out  4  driven from the latched opcode.
- alu_cin  out  1  driven from the carry register.
- alu_out  in  WIDTH  ALU result.
- alu_cout  in  1  ALU carry-out.
- alu_zero  in  1  ALU zero flag.
- alu_neg  in  1  ALU negative flag.
- alu_ovf  in  1  ALU overflow flag.
- alu_par  in  1  ALU parity flag.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts the response.
- rsp_data  out  WIDTH  accumulator value.
- rsp_flags  out  5  status register, {c, z, n, v, p}.

## Operation
- States:
  - IDLE (cmd_ready=1).
  - EXEC (ALU result captured every cycle).
  - RESP (rsp_valid=1).
- IDLE:
  - Command is accepted when cmd_valid && cmd_ready.
  - Accept with cmd_load=1: acc <= cmd_operand; carry and status are unchanged; next state RESP.
  - Accept with cmd_load=0: op_q <= cmd_op; b_q <= cmd_operand; remaining <= (cmd_count==0 ? 1 : cmd_count); next state EXEC.
- EXEC, every cycle:
  - acc <= alu_out
  - carry <= alu_cout
  - status <= {alu_cout, alu_zero, alu_neg, alu_ovf, alu_par}
  - remaining <= remaining-1
  - When remaining==1, next state is RESP.
- The carry register persists across commands. ADD_WITH_CIN and SUB_WITH_CIN therefore chain on the previous command's carry.
- RESP:
  - rsp_data=acc and rsp_flags=status, held stable while rsp_valid && !rsp_ready.
  - On rsp_ready the sequencer returns to IDLE.
- ALU drive outputs are pure register outputs (acc, b_q, op_q, carry) in every state. The ALU result is only captured in EXEC.
- Width rules: all arithmetic is done inside the ALU. The remaining counter is CNTW bits and never wraps: 0 is converted to 1 at accept.

## Timing
- Reset values:
  - state IDLE; cmd_ready=1; rsp_valid=0.
  - acc=0, carry=0, status=0, b_q=0, op_q=0, remaining=0.
  - Hence alu_a=alu_b=alu_cin=alu_op=0 and rsp_data=0, rsp_flags=0.
- Reset mid-EXEC or mid-RESP aborts immediately. No response is produced for the aborted command.
- Latency, measured from the accept edge E0:
  - Operate command: EXEC updates on edges E1..EN; rsp_valid is high from the cycle after EN. Accept-to-response is N edges, N = effective count.
  - Load command: rsp_valid is high in the cycle right after E0.
- Throughput: the earliest next accept is the cycle after the rsp handshake edge. cmd_ready is low from E0 through the response handshake edge.
- rsp_ready is ignored outside RESP.
- cmd_valid while cmd_ready=0 is ignored; there is no command buffering.

## Test plan
- **Add with overflow (WIDTH=8):** load 0x7F, then ADD 0x01 count 1 → rsp_data 0x80, flags c0 z0 n1 v1 p1; rsp_valid one edge after accept.
- **Multi-bit shift:** load 0x01, then SHIFT_LEFT count 7 → 0x80, rsp_valid 7 edges after accept. Repeat with count 8 from 0x01 → 0x00, flags c1 z1 n0.
- **Count zero treated as one:** load 0xFF, then INCREMENT count 0 → exactly one EXEC cycle, rsp_data 0x00, z=1.
- **Carry chain:** load 0xFF, ADD 0x01 (c_out=1 captured), then load 0x00, then ADD_WITH_CIN 0x00 → rsp_data 0x01.
- **Response backpressure:** hold rsp_ready=0 for 5 cycles in RESP → rsp_valid, rsp_data and rsp_flags stable; cmd_ready=0; a cmd_valid pulse is ignored.
- **Reset mid-operation:** SHIFT_LEFT count 10 from 0x01, assert rst_n=0 at EXEC cycle 4 → rsp_valid 0, acc 0, cmd_ready 1 immediately; no response afterwards.

Source files
------------

// File: rtl/alu_sequencer.sv
// Sequential front-end for the combinational ALU: accepts a command, iterates
// the opcode with the accumulator fed back as operand A, then returns result/flags.
module alu_sequencer #(
  parameter int WIDTH = 8,
  parameter int CNTW  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_load,
  input  logic [3:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_operand,
  input  logic [CNTW-1:0]  cmd_count,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_op,
  output logic             alu_cin,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_cout,
  input  logic             alu_zero,
  input  logic             alu_neg,
  input  logic             alu_ovf,
  input  logic             alu_par,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic [4:0]       rsp_flags
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, b_q;
  logic [3:0]       op_q;
  logic             carry_q;
  logic [4:0]       status_q;
  logic [CNTW-1:0]  rem_q;
  logic             cmd_fire;

  assign cmd_fire = cmd_valid && (state_q == IDLE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cmd_valid) state_d = cmd_load ? RESP : EXEC;
      EXEC:    if (rem_q == CNTW'(1)) state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Carry deliberately survives across commands so *_WITH_CIN ops chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      b_q      <= '0;
      op_q     <= '0;
      carry_q  <= 1'b0;
      status_q <= '0;
      rem_q    <= '0;
    end else if (cmd_fire) begin
      if (cmd_load) begin
        acc_q <= cmd_operand;
      end else begin
        op_q  <= cmd_op;
        b_q   <= cmd_operand;
        rem_q <= (cmd_count == '0) ? CNTW'(1) : cmd_count;
      end
    end else if (state_q == EXEC) begin
      acc_q    <= alu_out;
      carry_q  <= alu_cout;
      status_q <= {alu_cout, alu_zero, alu_neg, alu_ovf, alu_par};
      rem_q    <= rem_q - CNTW'(1);
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_data  = acc_q;
  assign rsp_flags = status_q;
  assign alu_a     = acc_q;
  assign alu_b     = b_q;
  assign alu_op    = op_q;
  assign alu_cin   = carry_q;

endmodule
